change_dispense_ctrl: RTL

Sequences the coin-ejector mechanism that returns change after a vend. The vend controller hands over a change amount with a one-cycle start pulse. This block pays it out greedily (25/10/5 units), one coin per ejector handshake, and tracks per-denomination coin inventory. It reports done, or err on an unpayable amount, an empty inventory or an ejector jam, and sits between the vend controller and the ejector.

---
 rtl/change_dispense_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
// Pays out a change amount one coin at a time through a handshaked ejector.
// Coins are chosen greedily (25, then 10, then 5). The block keeps a count of
// each denomination it holds. It finishes with a one-cycle done pulse, or with
// a one-cycle err pulse when the amount cannot be paid, the inventory runs
// out, or the ejector never acknowledges a request.

module change_dispense_ctrl #(
   parameter int AMT_W       = 8,
   parameter int INV_W       = 4,
   parameter int INIT_CNT    = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] change_amt,
   input  logic             refill,
   input  logic [INV_W-1:0] refill_n25,
   input  logic [INV_W-1:0] refill_n10,
   input  logic [INV_W-1:0] refill_n5,
   input  logic             eject_ack,
   output logic             eject_req,
   output logic [1:0]       coin_out_sel,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [AMT_W-1:0] remaining,
   output logic [INV_W-1:0] inv25,
   output logic [INV_W-1:0] inv10,
   output logic [INV_W-1:0] inv5
);

   // The timeout counter must be able to hold ACK_TIMEOUT-1. The extra bit
   // from +1 keeps the width at least one even when ACK_TIMEOUT is 1.
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_5    = 2'b01;
   localparam logic [1:0] SEL_10   = 2'b10;
   localparam logic [1:0] SEL_25   = 2'b11;

   localparam logic [AMT_W-1:0] VAL_5    = AMT_W'(5);
   localparam logic [AMT_W-1:0] VAL_10   = AMT_W'(10);
   localparam logic [AMT_W-1:0] VAL_25   = AMT_W'(25);
   localparam logic [AMT_W-1:0] AMT_ZERO = '0;

   localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);
   localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_CNT);

   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SELECT,
      EJECT,
      DONE,
      ERR
   } state_t;

   state_t state;
   state_t state_next;

   logic [AMT_W-1:0] remaining_next;
   logic [INV_W-1:0] inv25_next;
   logic [INV_W-1:0] inv10_next;
   logic [INV_W-1:0] inv5_next;
   logic [1:0]       sel_q;
   logic [1:0]       sel_next;
   logic [TMO_W-1:0] tmo_q;
   logic [TMO_W-1:0] tmo_next;

   logic             can_25;
   logic             can_10;
   logic             can_5;
   logic             not_multiple_of_5;
   logic [AMT_W-1:0] coin_value;

   // A denomination is usable only if it fits in the balance and a coin is on
   // hand. This guarantees that neither the balance nor a counter can wrap.
   always_comb begin
      can_25            = (remaining >= VAL_25) && (inv25 != '0);
      can_10            = (remaining >= VAL_10) && (inv10 != '0);
      can_5             = (remaining >= VAL_5)  && (inv5  != '0);
      not_multiple_of_5 = ((remaining % VAL_5) != AMT_ZERO);
      coin_value        = AMT_ZERO;
      case (sel_q)
         SEL_25:  coin_value = VAL_25;
         SEL_10:  coin_value = VAL_10;
         SEL_5:   coin_value = VAL_5;
         default: coin_value = AMT_ZERO;
      endcase
   end

   // Next-state logic. This block also computes the next balance, the next
   // inventory counts, the next latched coin and the next timeout count.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      inv25_next     = inv25;
      inv10_next     = inv10;
      inv5_next      = inv5;
      sel_next       = sel_q;
      tmo_next       = tmo_q;

      case (state)
         IDLE: begin
            if (refill) begin
               inv25_next = refill_n25;
               inv10_next = refill_n10;
               inv5_next  = refill_n5;
            end
            if (start) begin
               remaining_next = change_amt;
               state_next     = CHECK;
            end
         end

         CHECK: begin
            if (not_multiple_of_5) begin
               state_next = ERR;
            end else if (remaining == AMT_ZERO) begin
               state_next = DONE;
            end else begin
               state_next = SELECT;
            end
         end

         SELECT: begin
            tmo_next = '0;
            if (can_25) begin
               sel_next   = SEL_25;
               state_next = EJECT;
            end else if (can_10) begin
               sel_next   = SEL_10;
               state_next = EJECT;
            end else if (can_5) begin
               sel_next   = SEL_5;
               state_next = EJECT;
            end else begin
               sel_next   = SEL_NONE;
               state_next = ERR;
            end
         end

         EJECT: begin
            if (eject_ack) begin
               remaining_next = remaining - coin_value;
               case (sel_q)
                  SEL_25:  inv25_next = inv25 - INV_ONE;
                  SEL_10:  inv10_next = inv10 - INV_ONE;
                  SEL_5:   inv5_next  = inv5  - INV_ONE;
                  default: inv5_next  = inv5;
               endcase
               state_next = CHECK;
            end else if (tmo_q == TMO_LAST) begin
               state_next = ERR;
            end else begin
               tmo_next = tmo_q + TMO_ONE;
            end
         end

         DONE: begin
            remaining_next = AMT_ZERO;
            state_next     = IDLE;
         end

         ERR: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, balance, inventory and handshake bookkeeping registers. Reset
   // overrides everything, including an eject that is in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= AMT_ZERO;
         inv25     <= INV_INIT;
         inv10     <= INV_INIT;
         inv5      <= INV_INIT;
         sel_q     <= SEL_NONE;
         tmo_q     <= '0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         inv25     <= inv25_next;
         inv10     <= inv10_next;
         inv5      <= inv5_next;
         sel_q     <= sel_next;
         tmo_q     <= tmo_next;
      end
   end

   // Moore outputs decoded from the state register. The coin select reads
   // 00 whenever no request is being presented to the ejector.
   always_comb begin
      eject_req    = (state == EJECT);
      coin_out_sel = (state == EJECT) ? sel_q : SEL_NONE;
      busy         = (state != IDLE);
      done         = (state == DONE);
      err          = (state == ERR);
   end

endmodule
